// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma key sequencer.
// Letters are 0..25 in a 5-bit field; positions wrap 25 -> 0.
package enigma_pkg;

   localparam int ALPHA = 26;
   localparam int LW    = 5;
   localparam int CW    = 6;

   typedef logic [LW-1:0] letter_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_STEP = 2'd1;
   localparam logic [1:0] ST_ENC  = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_STEP = ST_STEP,
      S_ENC  = ST_ENC,
      S_HOLD = ST_HOLD
   } state_e;

   // Advance one position, wrapping 25 back to 0.
   function automatic letter_t incr26(input letter_t v);
      return (v >= letter_t'(ALPHA - 1)) ? '0 : v + letter_t'(1);
   endfunction

   // Fold an out-of-range start position back into 0..25.
   function automatic letter_t wrap26(input letter_t v);
      return (v >= letter_t'(ALPHA)) ? v - letter_t'(ALPHA) : v;
   endfunction

endpackage

// File: rtl/enigma_rotor_stepper.sv
// Combinational next rotor positions for one key press.
// Rotor 1 always moves; rotors 2/3 follow the notch rules.
module enigma_rotor_stepper
   import enigma_pkg::*;
#(
   parameter int NOTCH1   = 16,
   parameter int NOTCH2   = 4,
   parameter bit DBL_STEP = 1'b1
) (
   input  logic [LW-1:0] r1_i,
   input  logic [LW-1:0] r2_i,
   input  logic [LW-1:0] r3_i,
   output logic [LW-1:0] r1_o,
   output logic [LW-1:0] r2_o,
   output logic [LW-1:0] r3_o
);

   logic at_n1;
   logic at_n2;

   // Odometer carry plus optional double-step of rotor 2
   always_comb begin
      at_n1 = (r1_i == letter_t'(NOTCH1));
      at_n2 = (r2_i == letter_t'(NOTCH2));
      r1_o  = incr26(r1_i);
      r2_o  = (at_n1 || (DBL_STEP && at_n2)) ? incr26(r2_i) : r2_i;
      r3_o  = at_n2 ? incr26(r3_i) : r3_i;
   end

endmodule

// File: rtl/enigma_key_sequencer.sv
// Handshake front-end for the rotor/reflector datapath.
// Steps rotors, holds datapath inputs for SETTLE cycles, returns result.
module enigma_key_sequencer
   import enigma_pkg::*;
#(
   parameter int NOTCH1   = 16,
   parameter int NOTCH2   = 4,
   parameter int SETTLE   = 2,
   parameter bit DBL_STEP = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_load,
   input  logic [LW-1:0] cfg_r1,
   input  logic [LW-1:0] cfg_r2,
   input  logic [LW-1:0] cfg_r3,
   input  logic          cfg_mode,
   input  logic          in_valid,
   input  logic [LW-1:0] in_char,
   output logic          in_ready,
   output logic          out_valid,
   output logic [LW-1:0] out_char,
   output logic          out_err,
   input  logic          out_ready,
   output logic [LW-1:0] enc_in,
   output logic [LW-1:0] enc_r1,
   output logic [LW-1:0] enc_r2,
   output logic [LW-1:0] enc_r3,
   output logic          enc_mode,
   output logic          enc_signal,
   output logic [CW-1:0] enc_counter,
   input  logic [LW-1:0] enc_out
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_e        state_q, state_d;
   logic [LW-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
   logic [LW-1:0] in_q, in_d;
   logic [LW-1:0] och_q, och_d;
   logic          oerr_q, oerr_d;
   logic          mode_q, mode_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [LW-1:0] n1, n2, n3;

   enigma_rotor_stepper #(
      .NOTCH1   (NOTCH1),
      .NOTCH2   (NOTCH2),
      .DBL_STEP (DBL_STEP)
   ) u_stepper (
      .r1_i (r1_q),
      .r2_i (r2_q),
      .r3_i (r3_q),
      .r1_o (n1),
      .r2_o (n2),
      .r3_o (n3)
   );

   // State and datapath-facing registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         r1_q     <= '0;
         r2_q     <= '0;
         r3_q     <= '0;
         in_q     <= '0;
         och_q    <= '0;
         oerr_q   <= 1'b0;
         mode_q   <= 1'b0;
         cnt_q    <= '0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         r1_q     <= r1_d;
         r2_q     <= r2_d;
         r3_q     <= r3_d;
         in_q     <= in_d;
         och_q    <= och_d;
         oerr_q   <= oerr_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
      end
   end

   // Next-state: load/accept, step, settle, hold until consumed
   always_comb begin
      state_d  = state_q;
      r1_d     = r1_q;
      r2_d     = r2_q;
      r3_d     = r3_q;
      in_d     = in_q;
      och_d    = och_q;
      oerr_d   = oerr_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      unique case (state_q)
         S_IDLE: begin
            if (cfg_load) begin
               r1_d   = wrap26(cfg_r1);
               r2_d   = wrap26(cfg_r2);
               r3_d   = wrap26(cfg_r3);
               mode_d = cfg_mode;
               cnt_d  = '0;
            end else if (in_valid) begin
               in_d = in_char;
               if (in_char > letter_t'(ALPHA - 1)) begin
                  och_d   = in_char;
                  oerr_d  = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  oerr_d  = 1'b0;
                  state_d = S_STEP;
               end
            end
         end
         S_STEP: begin
            r1_d     = n1;
            r2_d     = n2;
            r3_d     = n3;
            cnt_d    = cnt_q + CW'(1);
            settle_d = SW'(SETTLE - 1);
            state_d  = S_ENC;
         end
         S_ENC: begin
            if (settle_q == '0) begin
               och_d   = enc_out;
               state_d = S_HOLD;
            end else begin
               settle_d = settle_q - SW'(1);
            end
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_HOLD);
   assign enc_signal  = (state_q == S_ENC);
   assign out_char    = och_q;
   assign out_err     = oerr_q;
   assign enc_in      = in_q;
   assign enc_r1      = r1_q;
   assign enc_r2      = r2_q;
   assign enc_r3      = r3_q;
   assign enc_mode    = mode_q;
   assign enc_counter = cnt_q;

endmodule

// File: tb/tb_enigma_key_sequencer.sv
// Randomised bench for enigma_key_sequencer against a transaction model.
// Two DUTs share stimulus: one double-stepping, one plain carry.
module tb_enigma_key_sequencer;

   localparam int SETTLE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cfg_load = 1'b0, cfg_mode = 1'b0;
   logic [4:0] cfg_r1 = '0, cfg_r2 = '0, cfg_r3 = '0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [4:0] in_char = '0;

   logic a_in_ready, a_out_valid, a_out_err, a_enc_mode, a_enc_signal;
   logic [4:0] a_out_char, a_enc_in, a_enc_r1, a_enc_r2, a_enc_r3, a_enc_out;
   logic [5:0] a_enc_counter;
   logic b_in_ready, b_out_valid, b_out_err, b_enc_mode, b_enc_signal;
   logic [4:0] b_out_char, b_enc_in, b_enc_r1, b_enc_r2, b_enc_r3, b_enc_out;
   logic [5:0] b_enc_counter;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Stand-in datapath: any fixed mixing of inputs will do
   function automatic logic [4:0] df(input int ch, r1, r2, r3, m);
      return 5'((ch + r1 + 3 * r2 + 7 * r3 + 11 * m) % 26);
   endfunction

   assign a_enc_out = df(int'(a_enc_in), int'(a_enc_r1), int'(a_enc_r2),
                         int'(a_enc_r3), int'(a_enc_mode));
   assign b_enc_out = df(int'(b_enc_in), int'(b_enc_r1), int'(b_enc_r2),
                         int'(b_enc_r3), int'(b_enc_mode));

   enigma_key_sequencer #(.NOTCH1(16), .NOTCH2(4), .SETTLE(SETTLE),
                          .DBL_STEP(1'b1)) u_a (
      .clk(clk), .rst(rst), .cfg_load(cfg_load),
      .cfg_r1(cfg_r1), .cfg_r2(cfg_r2), .cfg_r3(cfg_r3),
      .cfg_mode(cfg_mode), .in_valid(in_valid), .in_char(in_char),
      .in_ready(a_in_ready), .out_valid(a_out_valid),
      .out_char(a_out_char), .out_err(a_out_err), .out_ready(out_ready),
      .enc_in(a_enc_in), .enc_r1(a_enc_r1), .enc_r2(a_enc_r2),
      .enc_r3(a_enc_r3), .enc_mode(a_enc_mode),
      .enc_signal(a_enc_signal), .enc_counter(a_enc_counter),
      .enc_out(a_enc_out)
   );

   enigma_key_sequencer #(.NOTCH1(16), .NOTCH2(4), .SETTLE(SETTLE),
                          .DBL_STEP(1'b0)) u_b (
      .clk(clk), .rst(rst), .cfg_load(cfg_load),
      .cfg_r1(cfg_r1), .cfg_r2(cfg_r2), .cfg_r3(cfg_r3),
      .cfg_mode(cfg_mode), .in_valid(in_valid), .in_char(in_char),
      .in_ready(b_in_ready), .out_valid(b_out_valid),
      .out_char(b_out_char), .out_err(b_out_err), .out_ready(out_ready),
      .enc_in(b_enc_in), .enc_r1(b_enc_r1), .enc_r2(b_enc_r2),
      .enc_r3(b_enc_r3), .enc_mode(b_enc_mode),
      .enc_signal(b_enc_signal), .enc_counter(b_enc_counter),
      .enc_out(b_enc_out)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Key-press rule on positions packed as {r3,r2,r1}
   function automatic logic [14:0] mstep(input logic [14:0] p, input bit dbl);
      int r1, r2, r3, n1, n2, n3;
      r1 = int'(p[4:0]);
      r2 = int'(p[9:5]);
      r3 = int'(p[14:10]);
      n1 = (r1 + 1) % 26;
      n2 = (r1 == 16 || (dbl && r2 == 4)) ? (r2 + 1) % 26 : r2;
      n3 = (r2 == 4) ? (r3 + 1) % 26 : r3;
      return {5'(n3), 5'(n2), 5'(n1)};
   endfunction

   // Transaction model: age counts cycles since the letter was accepted
   bit         busy = 0, m_err = 0, chk_en = 0;
   int         age = 0, m_cnt = 0, m_mode = 0, m_in = 0;
   logic [14:0] cur [2];
   logic [14:0] nxt [2];
   int         m_out [2];

   function automatic bit e_ov();
      return busy && (m_err || age >= SETTLE + 2);
   endfunction

   function automatic bit e_enc();
      return busy && !m_err && age >= 2 && age <= SETTLE + 1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         busy = 0; age = 0; m_err = 0; m_cnt = 0; m_mode = 0; m_in = 0;
         cur[0] = '0; cur[1] = '0; m_out[0] = 0; m_out[1] = 0;
      end else if (!busy) begin
         if (cfg_load) begin
            cur[0] = {5'(cfg_r3 % 26), 5'(cfg_r2 % 26), 5'(cfg_r1 % 26)};
            cur[1] = cur[0];
            m_mode = int'(cfg_mode);
            m_cnt  = 0;
         end else if (in_valid) begin
            busy = 1; age = 1; m_in = int'(in_char);
            if (in_char > 25) begin
               m_err = 1; m_out[0] = m_in; m_out[1] = m_in;
            end else begin
               m_err = 0;
               nxt[0] = mstep(cur[0], 1'b1);
               nxt[1] = mstep(cur[1], 1'b0);
            end
         end
      end else if (e_ov() && out_ready) begin
         busy = 0;
      end else begin
         age++;
         if (!m_err && age == 2) begin
            cur[0] = nxt[0]; cur[1] = nxt[1];
            m_cnt = (m_cnt + 1) % 64;
         end
         if (!m_err && age == SETTLE + 2)
            for (int d = 0; d < 2; d++)
               m_out[d] = int'(df(m_in, int'(cur[d][4:0]), int'(cur[d][9:5]),
                                  int'(cur[d][14:10]), m_mode));
      end
   end

   task automatic cmp(input string p, input logic [14:0] pos, input int oexp,
                      input int ir, ov, es, oe, em, oc, ei, r1, r2, r3, ec);
      chk({p, " in_ready"}, ir, int'(!busy));
      chk({p, " out_valid"}, ov, int'(e_ov()));
      chk({p, " enc_signal"}, es, int'(e_enc()));
      chk({p, " enc_counter"}, ec, m_cnt);
      chk({p, " enc_mode"}, em, m_mode);
      chk({p, " enc_in"}, ei, m_in);
      chk({p, " enc_r1"}, r1, int'(pos[4:0]));
      chk({p, " enc_r2"}, r2, int'(pos[9:5]));
      chk({p, " enc_r3"}, r3, int'(pos[14:10]));
      if (e_ov()) begin
         chk({p, " out_char"}, oc, oexp);
         chk({p, " out_err"}, oe, int'(m_err));
      end
   endtask

   // Every cycle: both DUTs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("A", cur[0], m_out[0], int'(a_in_ready), int'(a_out_valid),
             int'(a_enc_signal), int'(a_out_err), int'(a_enc_mode),
             int'(a_out_char), int'(a_enc_in), int'(a_enc_r1),
             int'(a_enc_r2), int'(a_enc_r3), int'(a_enc_counter));
         cmp("B", cur[1], m_out[1], int'(b_in_ready), int'(b_out_valid),
             int'(b_enc_signal), int'(b_out_err), int'(b_enc_mode),
             int'(b_out_char), int'(b_enc_in), int'(b_enc_r1),
             int'(b_enc_r2), int'(b_enc_r3), int'(b_enc_counter));
      end
   end

   task automatic do_cfg(input int r1, r2, r3, m,
                         input bit with_valid, input int ch);
      @(negedge clk);
      cfg_load = 1'b1; cfg_r1 = 5'(r1); cfg_r2 = 5'(r2); cfg_r3 = 5'(r3);
      cfg_mode = m[0]; in_valid = with_valid; in_char = 5'(ch);
      @(posedge clk); #1;
      cfg_load = 1'b0; in_valid = 1'b0;
   endtask

   task automatic send(input int ch, input int hold,
                       output int oc, output int oe);
      int n;
      @(negedge clk);
      in_char = 5'(ch); in_valid = 1'b1; n = 0;
      while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("accept timeout", n, 0);
      @(posedge clk); #1;
      in_valid = 1'b0; n = 0;
      do begin @(negedge clk); n++; end while (!a_out_valid && n < 50);
      chk("latency", n, (ch > 25) ? 1 : SETTLE + 2);
      oc = int'(a_out_char); oe = int'(a_out_err);
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic pos_is(input string nm, input int r1, r2, r3);
      chk({nm, " r1"}, int'(a_enc_r1), r1);
      chk({nm, " r2"}, int'(a_enc_r2), r2);
      chk({nm, " r3"}, int'(a_enc_r3), r3);
   endtask

   initial begin
      #1000000;
      chk("watchdog", 1, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int oc, oe, n, ch;
      logic [14:0] p;
      cur[0] = '0; cur[1] = '0; nxt[0] = '0; nxt[1] = '0;
      m_out[0] = 0; m_out[1] = 0;

      // Pin the stepping rule with hand-computed values
      chk("mdl dbl a", int'(mstep({5'd0, 5'd3, 5'd16}, 1'b1)),
          int'({5'd0, 5'd4, 5'd17}));
      chk("mdl dbl b", int'(mstep({5'd0, 5'd4, 5'd17}, 1'b1)),
          int'({5'd1, 5'd5, 5'd18}));
      chk("mdl nodbl", int'(mstep({5'd0, 5'd4, 5'd17}, 1'b0)),
          int'({5'd1, 5'd4, 5'd18}));
      p = '0;
      for (int i = 0; i < 26; i++) p = mstep(p, 1'b1);
      chk("mdl 26 keys", int'(p), int'({5'd0, 5'd1, 5'd0}));
      p = '0;
      for (int i = 0; i < 676; i++) p = mstep(p, 1'b0);
      chk("mdl 676 keys", int'(p), 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1;
      chk("rst out_valid", int'(a_out_valid), 0);
      chk("rst enc_counter", int'(a_enc_counter), 0);
      chk("rst out_char", int'(a_out_char), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst in_ready", int'(a_in_ready), 1);

      // Basic key and latency
      do_cfg(0, 0, 0, 0, 1'b0, 0);
      send(0, 0, oc, oe);
      pos_is("t1", 1, 0, 0);
      chk("t1 counter", int'(a_enc_counter), 1);
      chk("t1 out_char", oc, 1);

      // Notch carry and wrap, out-of-range load
      do_cfg(16, 0, 0, 0, 1'b0, 0);
      send(5, 1, oc, oe);
      pos_is("t2 notch", 17, 1, 0);
      do_cfg(25, 0, 0, 0, 1'b0, 0);
      send(5, 0, oc, oe);
      pos_is("t2 wrap", 0, 0, 0);
      do_cfg(30, 27, 0, 1, 1'b0, 0);
      send(2, 0, oc, oe);
      pos_is("t2 fold", 5, 1, 0);

      // Double step on A, plain carry on B
      do_cfg(16, 3, 0, 0, 1'b0, 0);
      send(7, 0, oc, oe);
      pos_is("t3 k1", 17, 4, 0);
      send(7, 0, oc, oe);
      pos_is("t3 k2", 18, 5, 1);
      chk("t3 B r2", int'(b_enc_r2), 4);
      chk("t3 B r3", int'(b_enc_r3), 1);

      // Invalid letter passes through
      do_cfg(5, 6, 7, 0, 1'b0, 0);
      send(30, 2, oc, oe);
      chk("t4 out_char", oc, 30);
      chk("t4 out_err", oe, 1);
      pos_is("t4", 5, 6, 7);
      chk("t4 counter", int'(a_enc_counter), 0);

      // Long stall, then load wins over a same-cycle letter
      send(3, 10, oc, oe);
      chk("t5 counter", int'(a_enc_counter), 1);
      do_cfg(2, 2, 2, 1, 1'b1, 9);
      repeat (3) @(negedge clk);
      chk("t5 counter clr", int'(a_enc_counter), 0);
      chk("t5 in_ready", int'(a_in_ready), 1);
      pos_is("t5", 2, 2, 2);

      // Reset in the middle of ENC
      @(negedge clk);
      in_char = 5'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; n = 0;
      do begin @(negedge clk); n++; end while (!a_enc_signal && n < 20);
      chk("t6 reach enc", int'(a_enc_signal), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6 out_valid", int'(a_out_valid), 0);
      chk("t6 enc_signal", int'(a_enc_signal), 0);
      chk("t6 counter", int'(a_enc_counter), 0);
      pos_is("t6", 0, 0, 0);
      rst = 1'b0;
      repeat (SETTLE + 3) @(negedge clk);

      // Counter wraps after 64 letters
      do_cfg(0, 0, 0, 0, 1'b0, 0);
      for (int i = 0; i < 64; i++) send(i % 26, 0, oc, oe);
      chk("t6 wrap", int'(a_enc_counter), 0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            do_cfg($urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 1),
                   1'($urandom_range(0, 1)), $urandom_range(0, 31));
         end else begin
            ch = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31)
                                              : $urandom_range(0, 25);
            send(ch, $urandom_range(0, 3), oc, oe);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
